// File: rtl/memory_responder.sv
// Memory-side responder for the datapath memory interface: captures a request, waits a
// programmable number of cycles, accesses an internal word RAM and pulses ACK for one cycle.
module memory_responder #(
    parameter int          ADDR_W      = 12,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [15:0] MAR_in,
    input  logic [15:0] M_wdata,
    input  logic        REQ,
    input  logic        WE,
    output logic [15:0] M_rdata,
    output logic        ACK,
    output logic        BUSY,
    output logic        ERR,
    output logic [15:0] ERR_ADDR,
    input  logic        ERR_CLR
);
    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_WAIT   = 2'd1;
    localparam logic [1:0]  ST_ACCESS = 2'd2;
    localparam logic [1:0]  ST_ACK    = 2'd3;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);
    localparam logic [16:0] RAM_SPAN  = 17'(1 << ADDR_W);
    localparam int          DEPTH     = 1 << ADDR_W;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_nxt_s;
    logic [15:0]       addr_r;
    logic [15:0]       wdata_r;
    logic              we_r;
    logic [15:0]       rdata_r;
    logic              ack_r;
    logic              busy_r;
    logic              err_r;
    logic [15:0]       err_addr_r;
    logic [15:0]       ram_r [DEPTH];
    logic [16:0]       offset_s;
    logic              in_range_s;
    logic [ADDR_W-1:0] ram_idx_s;
    logic              access_s;
    logic              bad_access_s;

    // Window decode: a borrow in the 17-bit offset lands above RAM_SPAN, so one compare checks both bounds.
    always_comb begin
        offset_s     = {1'b0, addr_r} - {1'b0, BASE_ADDR};
        in_range_s   = (offset_s < RAM_SPAN);
        ram_idx_s    = offset_s[ADDR_W-1:0];
        access_s     = (state_r == ST_ACCESS);
        bad_access_s = access_s && !in_range_s;
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (REQ) begin
                    cnt_nxt_s   = WAIT_LOAD;
                    state_nxt_s = (WAIT_LOAD == 4'd0) ? ST_ACCESS : ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_nxt_s = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_ACCESS: state_nxt_s = ST_ACK;
            ST_ACK:    state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Control state, handshake outputs and the request captured at accept.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            ack_r   <= 1'b0;
            addr_r  <= 16'h0000;
            wdata_r <= 16'h0000;
            we_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            ack_r   <= access_s;
            if ((state_r == ST_IDLE) && REQ) begin
                addr_r  <= MAR_in;
                wdata_r <= M_wdata;
                we_r    <= WE;
            end
        end
    end

    // Read data return and sticky error capture; a new error outranks a same-cycle ERR_CLR.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            rdata_r    <= 16'h0000;
            err_r      <= 1'b0;
            err_addr_r <= 16'h0000;
        end else begin
            if (access_s && !we_r) begin
                rdata_r <= in_range_s ? ram_r[ram_idx_s] : 16'h0000;
            end
            if (bad_access_s) begin
                err_r <= 1'b1;
                if (ERR_CLR || !err_r) begin
                    err_addr_r <= addr_r;
                end
            end else if (ERR_CLR) begin
                err_r      <= 1'b0;
                err_addr_r <= 16'h0000;
            end
        end
    end

    // RAM contents survive reset; a write lands in a single edge so an abort never leaves it partial.
    always_ff @(posedge CLK) begin
        if (access_s && we_r && in_range_s) begin
            ram_r[ram_idx_s] <= wdata_r;
        end
    end

    assign M_rdata  = rdata_r;
    assign ACK      = ack_r;
    assign BUSY     = busy_r;
    assign ERR      = err_r;
    assign ERR_ADDR = err_addr_r;
endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: two instances (2 and 0 wait states), transaction-level reference
// model feeding a scoreboard that a monitor drains on every ACK.
module tb_memory_responder;
    logic        clk = 1'b0;
    logic        rst_n    [2];
    logic        req      [2];
    logic        we       [2];
    logic [15:0] mar      [2];
    logic [15:0] wdata    [2];
    logic        err_clr  [2];
    logic [15:0] m_rdata  [2];
    logic        ack      [2];
    logic        busy     [2];
    logic        err      [2];
    logic [15:0] err_addr [2];

    int cyc   = 0;
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          ack_cyc;
        logic [15:0] rdata;
        logic        err;
        logic [15:0] eaddr;
    } exp_t;

    exp_t        sb       [2][$];
    logic [15:0] mem_m    [2][4096];
    logic        err_m    [2];
    logic [15:0] eaddr_m  [2];
    logic [15:0] last_rd  [2];
    logic [15:0] pool     [2][12];
    logic        prev_ack [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_responder #(.ADDR_W(12), .BASE_ADDR(16'hF000), .WAIT_STATES(2)) dut0 (
        .CLK(clk), .CLR(rst_n[0]), .MAR_in(mar[0]), .M_wdata(wdata[0]), .REQ(req[0]), .WE(we[0]),
        .M_rdata(m_rdata[0]), .ACK(ack[0]), .BUSY(busy[0]), .ERR(err[0]), .ERR_ADDR(err_addr[0]),
        .ERR_CLR(err_clr[0]));

    memory_responder #(.ADDR_W(6), .BASE_ADDR(16'h0040), .WAIT_STATES(0)) dut1 (
        .CLK(clk), .CLR(rst_n[1]), .MAR_in(mar[1]), .M_wdata(wdata[1]), .REQ(req[1]), .WE(we[1]),
        .M_rdata(m_rdata[1]), .ACK(ack[1]), .BUSY(busy[1]), .ERR(err[1]), .ERR_ADDR(err_addr[1]),
        .ERR_CLR(err_clr[1]));

    function automatic int base_of(input int i);
        return (i == 0) ? 32'hF000 : 32'h0040;
    endfunction

    function automatic int aw_of(input int i);
        return (i == 0) ? 12 : 6;
    endfunction

    function automatic int ws_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at cycle %0d: got %0h, expected %0h", name, inst, cyc, act, exp);
        end
    endtask

    // One transfer applied to the abstract memory: returns what the ACK cycle must show.
    function automatic exp_t model_step(input int i, input logic w, input logic [15:0] a,
                                        input logic [15:0] d, input logic clr, input int t);
        exp_t e;
        int   off;
        int   idx;
        bit   inr;
        off = int'(a) - base_of(i);
        inr = (off >= 0) && (off < (1 << aw_of(i)));
        idx = off & ((1 << aw_of(i)) - 1);
        if (w) begin
            if (inr) mem_m[i][idx] = d;
        end else begin
            last_rd[i] = inr ? mem_m[i][idx] : 16'h0000;
        end
        if (!inr) begin
            if (clr || !err_m[i]) eaddr_m[i] = a;
            err_m[i] = 1'b1;
        end else if (clr) begin
            err_m[i]   = 1'b0;
            eaddr_m[i] = 16'h0000;
        end
        e.ack_cyc = t + ws_of(i) + 2;
        e.rdata   = last_rd[i];
        e.err     = err_m[i];
        e.eaddr   = eaddr_m[i];
        return e;
    endfunction

    task automatic xfer(input int i, input logic w, input logic [15:0] a, input logic [15:0] d, input logic clr);
        int t;
        @(negedge clk);
        req[i] = 1'b1; we[i] = w; mar[i] = a; wdata[i] = d;
        t = cyc;
        sb[i].push_back(model_step(i, w, a, d, clr, t));
        for (int c = t + 1; c <= t + ws_of(i) + 3; c++) begin
            @(negedge clk);
            if (c == t + 1) chk("busy_accept", i, 32'(busy[i]), 32'd1);
            req[i]     = 1'b0;
            err_clr[i] = (c == t + ws_of(i) + 1) ? clr : 1'b0;
        end
    endtask

    task automatic clear_err(input int i);
        @(negedge clk);
        err_clr[i] = 1'b1;
        @(negedge clk);
        err_clr[i] = 1'b0;
        err_m[i]   = 1'b0;
        eaddr_m[i] = 16'h0000;
        chk("errclr_err", i, 32'(err[i]), 32'(err_m[i]));
        chk("errclr_addr", i, 32'(err_addr[i]), 32'(eaddr_m[i]));
    endtask

    task automatic preload(input int i);
        for (int p = 0; p < 8; p++) xfer(i, 1'b1, pool[i][p], 16'($urandom), 1'b0);
    endtask

    task automatic run_random(input int i, input int n);
        int p;
        for (int k = 0; k < n; k++) begin
            p = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 11) : $urandom_range(0, 7);
            xfer(i, 1'($urandom_range(0, 1)), pool[i][p], 16'($urandom), ($urandom_range(0, 7) == 0));
        end
    endtask

    // REQ held high throughout: a new accept is due every WAIT_STATES+3 cycles.
    task automatic run_stream(input int i, input int n);
        int          t;
        int          p;
        logic        w;
        logic [15:0] d;
        @(negedge clk);
        req[i] = 1'b1;
        for (int k = 0; k < n; k++) begin
            p = $urandom_range(0, 11);
            w = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            we[i] = w; mar[i] = pool[i][p]; wdata[i] = d;
            t = cyc;
            sb[i].push_back(model_step(i, w, pool[i][p], d, 1'b0, t));
            repeat (ws_of(i) + 3) @(negedge clk);
        end
        req[i] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every ACK must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (ack[i] === 1'b1) begin
                chk("ack_gap", i, 32'(prev_ack[i]), 32'd0);
                if (sb[i].size() == 0) begin
                    chk("ack_unexpected", i, 32'(sb[i].size()), 32'd1);
                end else begin
                    e = sb[i].pop_front();
                    chk("ack_latency", i, 32'(cyc), 32'(e.ack_cyc));
                    chk("busy_at_ack", i, 32'(busy[i]), 32'd1);
                    chk("rdata", i, 32'(m_rdata[i]), 32'(e.rdata));
                    chk("err", i, 32'(err[i]), 32'(e.err));
                    chk("err_addr", i, 32'(err_addr[i]), 32'(e.eaddr));
                end
            end else if (sb[i].size() > 0 && cyc > sb[i][0].ack_cyc) begin
                chk("ack_missing", i, 32'(ack[i]), 32'd1);
                void'(sb[i].pop_front());
            end
            prev_ack[i] <= ack[i];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        prev_ack = '{1'b0, 1'b0};
        pool[0] = '{16'hF000, 16'hFFFF, 16'hF010, 16'hF123, 16'hF800, 16'hFABC, 16'hF001, 16'hFFFE,
                    16'hEFFF, 16'h0000, 16'h0010, 16'hE000};
        pool[1] = '{16'h0040, 16'h007F, 16'h0041, 16'h0055, 16'h0060, 16'h006A, 16'h0070, 16'h007E,
                    16'h003F, 16'h0080, 16'h0000, 16'hFFFF};
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; mar[i] = 16'h0000;
            wdata[i] = 16'h0000; err_clr[i] = 1'b0;
            err_m[i] = 1'b0; eaddr_m[i] = 16'h0000; last_rd[i] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ack", i, 32'(ack[i]), 32'd0);
            chk("rst_busy", i, 32'(busy[i]), 32'd0);
            chk("rst_rdata", i, 32'(m_rdata[i]), 32'd0);
            chk("rst_err", i, 32'(err[i]), 32'd0);
            chk("rst_err_addr", i, 32'(err_addr[i]), 32'd0);
            rst_n[i] = 1'b1;
        end

        fork
            preload(0);
            preload(1);
        join

        // Directed sequence on the 2-wait-state instance (window F000..FFFF).
        xfer(0, 1'b1, 16'hF010, 16'hA5A5, 1'b0);
        xfer(0, 1'b0, 16'hF010, 16'h0000, 1'b0);
        xfer(0, 1'b0, 16'hEFFF, 16'h0000, 1'b0);
        xfer(0, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
        xfer(0, 1'b1, 16'hE000, 16'h1234, 1'b0);
        xfer(0, 1'b0, 16'hF000, 16'h0000, 1'b0);
        xfer(0, 1'b0, 16'h0010, 16'h0000, 1'b1);
        xfer(0, 1'b0, 16'hF010, 16'h0000, 1'b0);

        // Abort a read in its second wait cycle.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; mar[0] = 16'hF123;
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        chk("busy_in_wait", 0, 32'(busy[0]), 32'd1);
        rst_n[0] = 1'b0;
        #1;
        err_m[0] = 1'b0; eaddr_m[0] = 16'h0000; last_rd[0] = 16'h0000;
        chk("abort_ack", 0, 32'(ack[0]), 32'd0);
        chk("abort_busy", 0, 32'(busy[0]), 32'd0);
        chk("abort_rdata", 0, 32'(m_rdata[0]), 32'(last_rd[0]));
        chk("abort_err", 0, 32'(err[0]), 32'(err_m[0]));
        @(negedge clk);
        rst_n[0] = 1'b1;
        xfer(0, 1'b0, 16'hF010, 16'h0000, 1'b0);
        xfer(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        clear_err(0);

        run_stream(1, 8);

        fork
            run_random(0, 60);
            run_random(1, 60);
        join

        repeat (8) @(negedge clk);
        chk("sb_drain", 0, 32'(sb[0].size()), 32'd0);
        chk("sb_drain", 1, 32'(sb[1].size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
